spi_cfg_sequencer: RTL and testbench

- Parametrised successor to the fixed-length HMC7044 write sequencer.
- Walks a register ROM of NUM_ENTRIES entries and issues one SPI transaction per entry through the existing SPI master (spi_start/spi_done handshake).
- Adds software start/restart, a per-entry post-write wait, an spi_done timeout with error capture, and busy/done/error status.
- Sits between the configuration ROM and the SPI master in the clock-chip configuration path.

---
 rtl/spi_cfg_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_sequencer.sv
// Walks a register ROM and issues one SPI transaction per entry, with per-entry gaps, spi_done timeout and status.
// Define SPI_CFG_READBACK_EN to add a read pass that checks every entry against rom_exp.
module spi_cfg_sequencer #(
    parameter int unsigned NUM_ENTRIES = 153,
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned SPI_WIDTH   = 24,
    parameter int unsigned WAIT_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              spi_done,
    input  logic [WAIT_W-1:0] rom_wait,
    input  logic [DATA_W-1:0] spi_rd_data,
    input  logic [DATA_W-1:0] rom_exp,
    output logic              spi_start,
    output logic [1:0]        spi_cmd,
    output logic [7:0]        spi_width,
    output logic [IDX_W-1:0]  index,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [IDX_W-1:0]  err_index
);

    localparam int unsigned     TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       CMD_WR   = 2'b00;
    localparam logic [1:0]       CMD_RD   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_DONE, S_GAP, S_DONE, S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [IDX_W-1:0]  err_index_q, err_index_d;
    logic              spi_start_q, spi_start_d;
    logic [1:0]        spi_cmd_q, spi_cmd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [WAIT_W-1:0] gap_q, gap_d;
    logic              last_c, final_c, rd_bad_c, adv_c, fail_c;

`ifdef SPI_CFG_READBACK_EN
    logic              pass_q, pass_d;  // 0 = write pass, 1 = read pass
`else
    logic              unused_rb_c;
    assign unused_rb_c = ^{spi_rd_data, rom_exp};
`endif

    assign last_c = (index_q == LAST_IDX);

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        err_index_d = err_index_q;
        spi_start_d = 1'b0;
        spi_cmd_d   = spi_cmd_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        adv_c       = 1'b0;
        fail_c      = 1'b0;
`ifdef SPI_CFG_READBACK_EN
        pass_d      = pass_q;
        final_c     = last_c && pass_q;
        rd_bad_c    = pass_q && (spi_rd_data != rom_exp);
`else
        final_c     = last_c;
        rd_bad_c    = 1'b0;
`endif

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (cfg_start) begin
                    state_d     = S_ISSUE;
                    index_d     = '0;
                    err_index_d = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    spi_cmd_d   = CMD_WR;
`ifdef SPI_CFG_READBACK_EN
                    pass_d      = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_d     = S_WAIT_DONE;
                spi_start_d = 1'b1;
                tmo_d       = '0;
            end
            S_WAIT_DONE: begin
                tmo_d = tmo_q + TMO_W'(1);
                // spi_done has priority over a coincident timeout
                if (spi_done) begin
                    if (rd_bad_c) begin
                        fail_c = 1'b1;
                    end else if (final_c) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        spi_cmd_d = CMD_WR;
                    end else if (rom_wait == '0) begin
                        adv_c = 1'b1;
                    end else begin
                        gap_d   = rom_wait;
                        state_d = S_GAP;
                    end
                end else if ((TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST)) begin
                    fail_c = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == WAIT_W'(1)) begin
                    adv_c = 1'b1;
                end else begin
                    gap_d = gap_q - WAIT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (adv_c) begin
            state_d = S_ISSUE;
            index_d = last_c ? '0 : index_q + IDX_W'(1);
`ifdef SPI_CFG_READBACK_EN
            if (last_c) begin
                pass_d    = 1'b1;
                spi_cmd_d = CMD_RD;
            end
`endif
        end

        if (fail_c) begin
            state_d     = S_ERR;
            err_d       = 1'b1;
            err_index_d = index_q;
            busy_d      = 1'b0;
            spi_cmd_d   = CMD_WR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            err_index_q <= '0;
            spi_start_q <= 1'b0;
            spi_cmd_q   <= CMD_WR;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            gap_q       <= '0;
`ifdef SPI_CFG_READBACK_EN
            pass_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            err_index_q <= err_index_d;
            spi_start_q <= spi_start_d;
            spi_cmd_q   <= spi_cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
`ifdef SPI_CFG_READBACK_EN
            pass_q      <= pass_d;
`endif
        end
    end

    assign spi_start = spi_start_q;
    assign spi_cmd   = spi_cmd_q;
    assign spi_width = 8'(SPI_WIDTH);
    assign index     = index_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Self-checking bench for spi_cfg_sequencer: cycle vector table plus SPI-master model scenarios.
module tb_spi_cfg_sequencer;

    localparam int NE     = 4;
    localparam int IDX_W  = 8;
    localparam int WAIT_W = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic              spi_done = 1'b0;
    logic [WAIT_W-1:0] rom_wait = '0;
    logic [DATA_W-1:0] spi_rd_data = 8'hA5;
    logic [DATA_W-1:0] rom_exp = 8'hA5;
    logic              spi_start;
    logic [1:0]        spi_cmd;
    logic [7:0]        spi_width;
    logic [IDX_W-1:0]  index;
    logic              cfg_busy, cfg_done, cfg_err;
    logic [IDX_W-1:0]  err_index;

    always #5 clk = ~clk;

    spi_cfg_sequencer #(
        .NUM_ENTRIES(4), .IDX_W(8), .SPI_WIDTH(24), .WAIT_W(16), .TIMEOUT_CYC(16), .DATA_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .spi_done(spi_done),
        .rom_wait(rom_wait), .spi_rd_data(spi_rd_data), .rom_exp(rom_exp),
        .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_width(spi_width), .index(index),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index)
    );

    typedef struct {
        logic        start;
        logic        done;
        logic [15:0] wt;
        int          e_idx;
        int          e_start;
        int          e_busy;
        int          e_done;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit model_en = 1'b0;
    int resp_cnt = 0;
    bit hold_en = 1'b0;
    int hold_idx = 0;
    int gap_idx = -1;
    int st_idx[$];
    int st_cmd[$];
    int st_cyc[$];
    int dn_cyc[$];
    int idx_cyc[NE];
    int prev_idx = 0;
    int done_cyc = -1;
    int err_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit s, input bit d, input int w, input int ix,
                                input int es, input int eb, input int ed);
        vec_t r;
        r.start = s; r.done = d; r.wt = 16'(w);
        r.e_idx = ix; r.e_start = es; r.e_busy = eb; r.e_done = ed;
        return r;
    endfunction

    // One clock: sample outputs after the edge, then run the SPI master model for this cycle
    task automatic step();
        int ii;
        @(posedge clk);
        #1;
        cyc++;
        ii = int'(index);
        if (model_en) begin
            spi_done = 1'b0;
            if (spi_start) begin
                st_idx.push_back(ii);
                st_cmd.push_back(int'(spi_cmd));
                st_cyc.push_back(cyc);
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    spi_done = 1'b1;
                    dn_cyc.push_back(cyc);
                end
            end
            if (spi_start && !(hold_en && ii == hold_idx)) resp_cnt = 10;
            rom_wait    = (ii == gap_idx && spi_cmd == 2'b00) ? 16'd5 : 16'd0;
            spi_rd_data = (spi_cmd == 2'b01 && ii == 1) ? 8'h00 : 8'hA5;
        end
        if (ii != prev_idx && ii < NE) idx_cyc[ii] = cyc;
        prev_idx = ii;
        if (cfg_done && done_cyc < 0) done_cyc = cyc;
        if (cfg_err && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cfg_start = 1'b0; spi_done = 1'b0; resp_cnt = 0; rom_wait = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        st_idx.delete(); st_cmd.delete(); st_cyc.delete(); dn_cyc.delete();
        foreach (idx_cyc[i]) idx_cyc[i] = -1;
        prev_idx = int'(index); done_cyc = -1; err_cyc = -1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic run_to_end(input string name, input int budget);
        int n = 0;
        while (!(cfg_done || cfg_err) && n < budget) begin
            step();
            n++;
        end
        chk({name, " finished within budget"}, int'(cfg_done || cfg_err), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " index"}, int'(index), 0);
        chk({tag, " spi_start"}, int'(spi_start), 0);
        chk({tag, " spi_cmd"}, int'(spi_cmd), 0);
        chk({tag, " spi_width"}, int'(spi_width), 24);
        chk({tag, " busy"}, int'(cfg_busy), 0);
        chk({tag, " done"}, int'(cfg_done), 0);
        chk({tag, " err"}, int'(cfg_err), 0);
        chk({tag, " err_index"}, int'(err_index), 0);
    endtask

    initial begin
        vec_t tbl[15];
        int   n;
        int   nst;
        int   nwr;
        int   nrd;
        // start, done, rom_wait -> index, spi_start, busy, done after the edge
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 1, 0, 1, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 1, 1, 1, 0);
        tbl[5]  = mk(0, 1, 2, 1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 2, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 2, 1, 1, 0);
        tbl[9]  = mk(0, 1, 0, 3, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 3, 1, 1, 0);
        tbl[11] = mk(0, 1, 0, 3, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, 3, 0, 0, 1);
        tbl[13] = mk(1, 1, 0, 0, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 1, 0);

        do_reset();
        chk_reset_outputs("reset");

`ifndef SPI_CFG_READBACK_EN
        for (int i = 0; i < 15; i++) begin
            cfg_start = tbl[i].start;
            spi_done  = tbl[i].done;
            rom_wait  = tbl[i].wt;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d index", i), int'(index), tbl[i].e_idx);
            chk($sformatf("vec%0d spi_start", i), int'(spi_start), tbl[i].e_start);
            chk($sformatf("vec%0d busy", i), int'(cfg_busy), tbl[i].e_busy);
            chk($sformatf("vec%0d done", i), int'(cfg_done), tbl[i].e_done);
        end
        cfg_start = 1'b0; spi_done = 1'b0; rom_wait = '0;

        // Full write pass with a 5-cycle gap after entry 1
        do_reset();
        model_en = 1'b1; gap_idx = 1; hold_en = 1'b0;
        pulse_start();
        run_to_end("seq", 400);
        chk("seq done", int'(cfg_done), 1);
        chk("seq busy", int'(cfg_busy), 0);
        chk("seq err", int'(cfg_err), 0);
        chk("seq start count", st_idx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq start%0d index", i), st_idx[i], i);
            chk($sformatf("seq start%0d cmd", i), st_cmd[i], 0);
        end
        chk("seq done latency", done_cyc - dn_cyc[3], 1);
        chk("gap to index2", idx_cyc[2] - dn_cyc[1], 6);
        chk("gap to start2", st_cyc[2] - dn_cyc[1], 7);
        chk("no gap to index1", idx_cyc[1] - dn_cyc[0], 1);

        // Timeout on entry 2, then restart
        do_reset();
        gap_idx = -1; hold_en = 1'b1; hold_idx = 2;
        pulse_start();
        run_to_end("tmo", 400);
        chk("tmo err", int'(cfg_err), 1);
        chk("tmo err_index", int'(err_index), 2);
        chk("tmo busy", int'(cfg_busy), 0);
        chk("tmo done", int'(cfg_done), 0);
        chk("tmo start count", st_idx.size(), 3);
        chk("tmo latency", err_cyc - st_cyc[2], 16);
        repeat (30) step();
        chk("tmo no further start", st_idx.size(), 3);
        chk("tmo index held", int'(index), 2);
        hold_en = 1'b0;
        pulse_start();
        chk("restart err cleared", int'(cfg_err), 0);
        chk("restart err_index cleared", int'(err_index), 0);
        chk("restart index", int'(index), 0);
        chk("restart busy", int'(cfg_busy), 1);
        run_to_end("restart", 400);
        chk("restart done", int'(cfg_done), 1);
        chk("restart start count", st_idx.size(), 7);
`else
        // Read pass with a mismatching readback on entry 1
        do_reset();
        model_en = 1'b1; gap_idx = -1; hold_en = 1'b0;
        pulse_start();
        run_to_end("rb", 600);
        nwr = 0; nrd = 0;
        foreach (st_cmd[i]) begin
            if (st_cmd[i] == 0) nwr++;
            if (st_cmd[i] == 1) nrd++;
        end
        chk("rb writes", nwr, 4);
        chk("rb reads", nrd, 2);
        chk("rb err", int'(cfg_err), 1);
        chk("rb err_index", int'(err_index), 1);
        chk("rb done", int'(cfg_done), 0);
        chk("rb cmd after err", int'(spi_cmd), 0);
        chk("rb first read index", st_idx[4], 0);
`endif

        // Asynchronous reset while waiting on entry 3's spi_done
        do_reset();
        model_en = 1'b1; gap_idx = -1; hold_en = 1'b0;
        pulse_start();
        n = 0;
        while (st_idx.size() < 4 && n < 200) begin
            step();
            n++;
        end
        chk("rst reached entry3", st_idx.size(), 4);
        step();
        step();
        chk("rst pre index", int'(index), 3);
        chk("rst pre busy", int'(cfg_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        nst = st_idx.size();
        repeat (20) step();
        chk("rst spurious done no start", st_idx.size(), nst);
        chk("rst spurious done busy", int'(cfg_busy), 0);
        chk("rst spurious done done", int'(cfg_done), 0);
        chk("rst spurious done index", int'(index), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
